if_map_load_ctrl: RTL and testbench
===================================

# if_map_load_ctrl

Load sequencer for the 64-register input-feature-map buffer. It fetches a K×K window (K = 1..8) from eight column-interleaved feature-map SRAM banks. It generates the per-register `Reg_loads`, `Mux_Sel` and `Local_Reset` controls so that window pixel (r,c) lands in buffer register r*8+c. It sits between the convolution controller (start/config) and the buffer/SRAM read port; it drives the buffer's write side.

## Interface
- `ADDR_W`, 10: SRAM word-address width (shared across all 8 banks).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: load request; sampled only in IDLE.
- `k_m1` in 3: kernel size minus one (K = k_m1+1).
- `col_off` in 3: bank index holding window column 0.
- `base_addr` in ADDR_W: word address of window row 0.
- `row_stride` in ADDR_W: word-address increment between window rows.
- `rd_gnt` in 1: SRAM read grant; a read issues when `rd_en & rd_gnt`.
- `rd_en` out 1: read request to all 8 banks.
- `rd_addr` out ADDR_W: read word address, common to all banks.
- `Reg_loads` out 64: per-register load enable for the buffer.
- `Mux_Sel` out 192: 3-bit bank select per register; register i uses bits [3i+2:3i].
- `Local_Reset` out 64: per-register clear.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, CLEAR, READ, DRAIN, DONE.
- **IDLE**
  - On `start`: latch K, `col_off`, `base_addr`, `row_stride`; go to CLEAR.
  - `start` while not in IDLE is ignored.
- **split** = (col_off + K > 8). Each window row needs 1 read (no split) or 2 reads (split).
- **Mux_Sel**
  - Register r*8+c uses bank (c + col_off) mod 8.
  - Written at the start-accept edge; held constant until the next accepted start.
- **CLEAR**
  - `Local_Reset[i]`=1 for one cycle for every register with r≥K or c≥K; all other bits 0.
- **READ**
  - Row r, phase 0: address A_r = base_addr + r*row_stride, modulo 2^ADDR_W.
  - Row r, phase 1 (split only): address A_r+1, modulo 2^ADDR_W.
  - Phase-0 mask: registers r*8+c with c<K and c+col_off<8.
  - Phase-1 mask: registers r*8+c with c<K and c+col_off≥8.
  - `rd_en`=1 throughout READ. `rd_addr` holds while `rd_gnt`=0.
  - Reads are ordered row 0..K-1, phase 0 before phase 1.
- **Load timing:** at each issuing edge, `Reg_loads` is registered with that read's mask, so it is high in the following cycle, aligned with bank data. Otherwise `Reg_loads`=0.
- After the last granted read, go to DRAIN: `rd_en`=0 and the last mask is on `Reg_loads`.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **busy:** 1 in CLEAR, READ and DRAIN.
- **Reset:** asynchronous assertion at any time forces IDLE. All outputs go to 0 immediately: `rd_en`, `rd_addr`, `Reg_loads`, `Mux_Sel`, `Local_Reset`, `busy`, `done`. An interrupted load is abandoned.

## Timing
- Reads per load: R = K*(1+split).
- No stalls: start-accept edge → CLEAR (1 cycle) → READ (R cycles) → DRAIN (1 cycle) → DONE (1 cycle). `done` is high in cycle R+3 after the accept edge.
- Each `rd_gnt`=0 cycle in READ adds exactly one cycle and produces no `Reg_loads` the following cycle.
- SRAM read latency is fixed at 1 cycle after an issuing edge.
- `done` and `start` cannot coincide with acceptance; a new start is accepted in IDLE the cycle after DONE at the earliest.

## Test plan
- **Basic 3×3:** K=3, col_off=0, base=0x010, stride=0x020, rd_gnt=1.
  - Reads at 0x010, 0x030, 0x050 on consecutive cycles.
  - Reg_loads = 0x7, 0x700, 0x70000 on consecutive cycles.
  - Local_Reset pulse = 0xFFFF_FFFF_FFF8_F8F8.
  - Mux_Sel reg i = i mod 8.
  - done high 6 cycles after accept.
- **Split row:** K=4, col_off=6, base=0x100, stride=0x010.
  - Reads 0x100, 0x101, 0x110, 0x111, …
  - Row 0 Reg_loads = 0x3, then 0xC.
  - Mux_Sel reg0..3 = 6, 7, 0, 1.
  - 8 reads; done 11 cycles after accept.
- **Grant stall:** K=2, rd_gnt low 3 cycles during row 1.
  - rd_en stays 1 and rd_addr holds the row-1 address.
  - No Reg_loads during the stall.
  - done delayed by exactly 3 cycles versus unstalled.
- **Full window:** K=8, col_off=0.
  - 8 reads; Reg_loads = 0xFF << 8r.
  - Local_Reset stays all-zero.
  - done 11 cycles after accept.
- **Reset mid-load:** reset asserted during row 2 of a K=5 load.
  - All outputs 0 in the same cycle.
  - After release, a fresh K=1 start completes in 4 cycles with Reg_loads = 0x1.
- **Wrap / ignored start:** ADDR_W=10, base=0x3FF, stride=1, K=2, col_off=7.
  - Reads 0x3FF, 0x000, 0x000, 0x001.
  - A start pulsed while busy has no effect on the sequence.

Source files
------------

// File: rtl/if_map_load_ctrl.sv
// Load sequencer for the 64-register input-feature-map buffer.
// Fetches a KxK window from eight column-interleaved SRAM banks. Window pixel
// (r,c) is steered into buffer register r*8+c. Reg_loads is registered so that
// it lines up with bank data one cycle after each granted read.
module if_map_load_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        k_m1,
  input  logic [2:0]        col_off,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic              rd_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       Reg_loads,
  output logic [191:0]      Mux_Sel,
  output logic [63:0]       Local_Reset,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [2:0]          col_q, col_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic [2:0]          row_q, row_d;
  logic                phase_q, phase_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [63:0]         loads_q, loads_d;
  logic [191:0]        mux_q, mux_d;
  logic [63:0]         lrst_q, lrst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [63:0]         clr_mask;
  logic [191:0]        mux_new;
  logic [7:0]          m0, m1;
  logic [3:0]          span;
  logic                split;

  // A row needs a second read when the window runs past bank 7.
  assign span  = {1'b0, col_q} + {1'b0, k_q};
  assign split = span[3];

  // Start-time decode from the live config: clear mask and per-register bank select.
  always_comb begin
    clr_mask = '0;
    mux_new  = '0;
    for (int i = 0; i < 64; i++) begin
      clr_mask[i]       = (3'(i / 8) > k_m1) || (3'(i % 8) > k_m1);
      mux_new[3*i +: 3] = 3'(i % 8) + col_off;
    end
  end

  // Column masks for phase 0 (banks col..7) and phase 1 (wrapped banks 0..).
  always_comb begin
    m0 = '0;
    m1 = '0;
    for (int c = 0; c < 8; c++) begin
      m0[c] = (3'(c) <= k_q) && (({1'b0, col_q} + 4'(c)) <  4'd8);
      m1[c] = (3'(c) <= k_q) && (({1'b0, col_q} + 4'(c)) >= 4'd8);
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    col_d      = col_q;
    stride_d   = stride_q;
    row_addr_d = row_addr_q;
    row_d      = row_q;
    phase_d    = phase_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    loads_d    = '0;
    mux_d      = mux_q;
    lrst_d     = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        k_d        = k_m1;
        col_d      = col_off;
        stride_d   = row_stride;
        row_addr_d = base_addr;
        lrst_d     = clr_mask;
        mux_d      = mux_new;
        busy_d     = 1'b1;
        state_d    = CLEAR;
      end
      CLEAR: begin
        state_d   = READ;
        rd_en_d   = 1'b1;
        rd_addr_d = row_addr_q;
        row_d     = '0;
        phase_d   = 1'b0;
      end
      READ: if (rd_gnt) begin
        loads_d = 64'(phase_q ? m1 : m0) << {row_q, 3'b000};
        if (split && !phase_q) begin
          phase_d   = 1'b1;
          rd_addr_d = row_addr_q + ADDR_W'(1);
        end else if (row_q == k_q) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          row_d      = row_q + 3'd1;
          phase_d    = 1'b0;
          row_addr_d = row_addr_q + stride_q;
          rd_addr_d  = row_addr_q + stride_q;
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any load in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      col_q      <= '0;
      stride_q   <= '0;
      row_addr_q <= '0;
      row_q      <= '0;
      phase_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      loads_q    <= '0;
      mux_q      <= '0;
      lrst_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      col_q      <= col_d;
      stride_q   <= stride_d;
      row_addr_q <= row_addr_d;
      row_q      <= row_d;
      phase_q    <= phase_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      loads_q    <= loads_d;
      mux_q      <= mux_d;
      lrst_q     <= lrst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign Reg_loads   = loads_q;
  assign Mux_Sel     = mux_q;
  assign Local_Reset = lrst_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_if_map_load_ctrl.sv
// Directed bench for if_map_load_ctrl: table of load configurations with
// hand-computed expectations, plus a reset-during-load sequence.
module tb_if_map_load_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   k_m1, col_off;
  logic [9:0]   base_addr, row_stride;
  logic         rd_gnt;
  logic         rd_en;
  logic [9:0]   rd_addr;
  logic [63:0]  Reg_loads;
  logic [191:0] Mux_Sel;
  logic [63:0]  Local_Reset;
  logic         busy, done;

  int nvec = 0;
  int nmis = 0;

  if_map_load_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .k_m1(k_m1), .col_off(col_off),
    .base_addr(base_addr), .row_stride(row_stride), .rd_gnt(rd_gnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .Reg_loads(Reg_loads), .Mux_Sel(Mux_Sel),
    .Local_Reset(Local_Reset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       k_m1;
    logic [2:0]       col;
    logic [9:0]       base;
    logic [9:0]       stride;
    int               stall_lo;   // rd_gnt low for cycles stall_lo..stall_hi (0 = none)
    int               stall_hi;
    int               ign_cyc;    // cycle at which a stray start is pulsed (0 = none)
    bit               rst_before; // run the reset-during-load sequence first
    int               done_cyc;
    logic [63:0]      lrst;
    logic [23:0]      mux;        // bank select of registers 0..7
    int               nreads;
    logic [7:0][9:0]  addrs;      // addrs[0] is the first read
    logic [63:0]      loads_or;
    logic [63:0]      ld0;
    logic [63:0]      ld1;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    k_m1 = 3'd4; col_off = 3'd0; base_addr = 10'h000; row_stride = 10'h010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);      // cycle 4: row 2 read in flight
    reset = 1'b0;
    #1;
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_rd_addr", rd_addr, 10'h0);
    chk("rst_loads", Reg_loads, 64'h0);
    chk("rst_mux", Mux_Sel, 192'h0);
    chk("rst_lrst", Local_Reset, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_idle_busy", busy, 1'b0);
  endtask

  task automatic run_load(input vec_t v);
    int          cyc;
    int          nissued;
    int          nloads;
    logic [63:0] lor;
    logic [63:0] l0, l1;
    bit          prev_issue, issue, got_done, gnt;
    nissued = 0; nloads = 0; lor = '0; l0 = '0; l1 = '0;
    prev_issue = 1'b0; got_done = 1'b0;
    if (v.rst_before) reset_mid_load();
    @(negedge clk);
    k_m1 = v.k_m1; col_off = v.col; base_addr = v.base; row_stride = v.stride;
    start = 1'b1; rd_gnt = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc <= 40) begin
      gnt = !(v.stall_lo != 0 && cyc >= v.stall_lo && cyc <= v.stall_hi);
      rd_gnt = gnt;
      if (v.ign_cyc != 0 && cyc == v.ign_cyc) begin
        start = 1'b1; k_m1 = 3'd7; col_off = 3'd0; base_addr = 10'h123; row_stride = 10'h055;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc == 1) begin
        chk("lrst_pulse", Local_Reset, v.lrst);
        chk("mux_sel", Mux_Sel, {8{v.mux}});
        chk("rd_en_clear", rd_en, 1'b0);
      end else begin
        chk("lrst_idle", Local_Reset, 64'h0);
      end
      chk("loads_valid", |Reg_loads, prev_issue);
      if (Reg_loads != 64'h0) begin
        if (nloads == 0) l0 = Reg_loads;
        if (nloads == 1) l1 = Reg_loads;
        nloads++;
        lor |= Reg_loads;
      end
      if (!gnt && nissued < v.nreads) begin
        chk("stall_rd_en", rd_en, 1'b1);
        chk("stall_addr", rd_addr, v.addrs[nissued]);
      end
      issue = rd_en && gnt;
      if (issue) begin
        if (nissued < v.nreads) chk("rd_addr", rd_addr, v.addrs[nissued]);
        nissued++;
      end
      prev_issue = issue;
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", cyc, v.done_cyc);
        chk("busy_at_done", busy, 1'b0);
        chk("mux_held", Mux_Sel, {8{v.mux}});
        break;
      end
      chk("busy", busy, 1'b1);
      @(negedge clk);
      cyc++;
    end
    rd_gnt = 1'b1;
    start  = 1'b0;
    if (!got_done) chk("done_timeout", 1'b0, 1'b1);
    chk("num_reads", nissued, v.nreads);
    chk("num_loads", nloads, v.nreads);
    chk("loads_or", lor, v.loads_or);
    chk("first_load", l0, v.ld0);
    if (v.nreads >= 2) chk("second_load", l1, v.ld1);
  endtask

  initial begin
    //        k  col base    stride  stl   ign rst done lrst                      mux           n  addrs (last..first)                                                        or                     ld0      ld1
    tv[0] = '{3'd2, 3'd0, 10'h010, 10'h020, 0, 0, 0, 0, 6,  64'hFFFF_FFFF_FFF8_F8F8, 24'o76543210, 3,
              {50'h0, 10'h050, 10'h030, 10'h010}, 64'h0000_0000_0007_0707, 64'h7, 64'h700};
    tv[1] = '{3'd3, 3'd6, 10'h100, 10'h010, 0, 0, 0, 0, 11, 64'hFFFF_FFFF_F0F0_F0F0, 24'o54321076, 8,
              {10'h131, 10'h130, 10'h121, 10'h120, 10'h111, 10'h110, 10'h101, 10'h100},
              64'h0000_0000_0F0F_0F0F, 64'h3, 64'hC};
    tv[2] = '{3'd7, 3'd0, 10'h000, 10'h008, 0, 0, 0, 0, 11, 64'h0, 24'o76543210, 8,
              {10'h038, 10'h030, 10'h028, 10'h020, 10'h018, 10'h010, 10'h008, 10'h000},
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 64'hFF00};
    tv[3] = '{3'd1, 3'd0, 10'h040, 10'h010, 3, 5, 0, 0, 8,  64'hFFFF_FFFF_FFFF_FCFC, 24'o76543210, 2,
              {60'h0, 10'h050, 10'h040}, 64'h0303, 64'h3, 64'h300};
    tv[4] = '{3'd1, 3'd7, 10'h3FF, 10'h001, 0, 0, 3, 0, 7,  64'hFFFF_FFFF_FFFF_FCFC, 24'o65432107, 4,
              {40'h0, 10'h001, 10'h000, 10'h000, 10'h3FF}, 64'h0303, 64'h1, 64'h2};
    tv[5] = '{3'd4, 3'd3, 10'h200, 10'h040, 0, 0, 0, 0, 8,  64'hFFFF_FFE0_E0E0_E0E0, 24'o21076543, 5,
              {30'h0, 10'h300, 10'h2C0, 10'h280, 10'h240, 10'h200},
              64'h0000_001F_1F1F_1F1F, 64'h1F, 64'h1F00};
    tv[6] = '{3'd0, 3'd0, 10'h055, 10'h003, 0, 0, 0, 1, 4,  64'hFFFF_FFFF_FFFF_FFFE, 24'o76543210, 1,
              {70'h0, 10'h055}, 64'h1, 64'h1, 64'h0};

    reset = 1'b0; start = 1'b0; rd_gnt = 1'b1;
    k_m1 = '0; col_off = '0; base_addr = '0; row_stride = '0;
    repeat (2) @(negedge clk);
    chk("reset_rd_en", rd_en, 1'b0);
    chk("reset_loads", Reg_loads, 64'h0);
    chk("reset_mux", Mux_Sel, 192'h0);
    chk("reset_lrst", Local_Reset, 64'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_load(tv[i]);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
